// File: rtl/cpu_run_ctrl_if.sv
// Run-control bundle between the debug harness and the core sequencer.
// master drives requests and core status, slave returns core gating.
interface cpu_run_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             run_req;
  logic             halt_req;
  logic             step_req;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic [31:0]      a0;
  logic             cpu_en;
  logic             cpu_rst;
  logic [1:0]       state;
  logic             halted;
  logic             bp_hit;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic [31:0]      a0_snap;

  modport master (
    output run_req, halt_req, step_req,
    output bp_en, bp_addr, pc, a0,
    input  cpu_en, cpu_rst, state, halted,
    input  bp_hit, cycle_cnt, instr_cnt, a0_snap
  );

  modport slave (
    input  run_req, halt_req, step_req,
    input  bp_en, bp_addr, pc, a0,
    output cpu_en, cpu_rst, state, halted,
    output bp_hit, cycle_cnt, instr_cnt, a0_snap
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the RV32I core.
// Gates core clock-enable and holds core reset after power-up.
module cpu_run_ctrl #(
  parameter int PC_W       = 32,
  parameter int RESET_HOLD = 4,
  parameter int CNT_W      = 32
) (
  input logic           clk,
  input logic           rst,
  cpu_run_ctrl_if.slave bus
);
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    HALT = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } st_t;

  st_t              st, st_nxt;
  logic [HW-1:0]    hold, hold_nxt;
  logic             skip, skip_nxt;
  logic             hit, hit_nxt;
  logic             match;
  logic             en;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] ret;
  logic [31:0]      snap;

  // skip lets a resumed run execute the instruction sitting at bp_addr
  assign match = (st == RUN) && bus.bp_en &&
                 (bus.pc == bus.bp_addr) && !skip;
  assign en    = ((st == RUN) && !match) || (st == STEP);

  always_comb begin
    st_nxt   = st;
    hold_nxt = hold;
    skip_nxt = skip;
    hit_nxt  = hit;
    unique case (st)
      INIT: begin
        if (hold == HOLD_LAST) begin
          st_nxt   = HALT;
          hold_nxt = '0;
        end else begin
          hold_nxt = hold + 1'b1;
        end
      end
      HALT: begin
        if (bus.halt_req) begin
          st_nxt = HALT;
        end else if (bus.step_req) begin
          st_nxt  = STEP;
          hit_nxt = 1'b0;
        end else if (bus.run_req) begin
          st_nxt   = RUN;
          hit_nxt  = 1'b0;
          skip_nxt = 1'b1;
        end
      end
      RUN: begin
        skip_nxt = 1'b0;
        if (match) begin
          st_nxt  = HALT;
          hit_nxt = 1'b1;
        end else if (bus.halt_req) begin
          st_nxt = HALT;
        end
      end
      STEP: st_nxt = HALT;
      default: st_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= INIT;
      hold <= '0;
      skip <= 1'b0;
      hit  <= 1'b0;
      cyc  <= '0;
      ret  <= '0;
      snap <= '0;
    end else begin
      st   <= st_nxt;
      hold <= hold_nxt;
      skip <= skip_nxt;
      hit  <= hit_nxt;
      if (st != INIT) cyc <= cyc + 1'b1;
      if (en)         ret <= ret + 1'b1;
      if (st == HALT) snap <= bus.a0;
    end
  end

  assign bus.cpu_en    = en;
  assign bus.cpu_rst   = (st == INIT);
  assign bus.state     = st;
  assign bus.halted    = (st == HALT);
  assign bus.bp_hit    = hit;
  assign bus.cycle_cnt = cyc;
  assign bus.instr_cnt = ret;
  assign bus.a0_snap   = snap;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset hold, step, breakpoint,
// request priority, async reset mid-run, counter wrap and a0 snapshot.
module tb_cpu_run_ctrl;
  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  cpu_run_ctrl_if #(.PC_W(32), .CNT_W(4)) bus ();

  cpu_run_ctrl #(
    .PC_W(32),
    .RESET_HOLD(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run        = 0;
    n_fail       = 0;
    rst          = 1'b0;
    bus.run_req  = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 32'h0;
    bus.pc       = 32'h0;
    bus.a0       = 32'h0;
    #2;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_cpurst", 32'(bus.cpu_rst), 32'd1);
    check("rst_cpuen", 32'(bus.cpu_en), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_bphit", 32'(bus.bp_hit), 32'd0);
    check("rst_cyc", 32'(bus.cycle_cnt), 32'd0);
    check("rst_ins", 32'(bus.instr_cnt), 32'd0);
    check("rst_snap", bus.a0_snap, 32'd0);

    // 1: four-edge reset hold, request during INIT dropped
    tick();
    rst = 1'b1;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    tick();
    tick();
    check("hold3_state", 32'(bus.state), 32'd0);
    check("hold3_cpurst", 32'(bus.cpu_rst), 32'd1);
    tick();
    check("hold4_state", 32'(bus.state), 32'd1);
    check("hold4_cpurst", 32'(bus.cpu_rst), 32'd0);
    check("hold4_halted", 32'(bus.halted), 32'd1);
    check("hold4_cpuen", 32'(bus.cpu_en), 32'd0);
    check("hold4_cyc", 32'(bus.cycle_cnt), 32'd0);
    check("hold4_ins", 32'(bus.instr_cnt), 32'd0);

    // 2: three single steps
    for (int i = 0; i < 3; i++) begin
      bus.step_req = 1'b1;
      #1;
      check("step_pre_en", 32'(bus.cpu_en), 32'd0);
      tick();
      bus.step_req = 1'b0;
      check("step_state", 32'(bus.state), 32'd3);
      check("step_en", 32'(bus.cpu_en), 32'd1);
      tick();
      check("step_back", 32'(bus.state), 32'd1);
      check("step_off", 32'(bus.cpu_en), 32'd0);
      tick();
      tick();
      tick();
    end
    check("step_ins", 32'(bus.instr_cnt), 32'd3);

    // 3: breakpoint at 0x10, then resume through it
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h10;
    bus.pc      = 32'h0;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    check("bp_run", 32'(bus.state), 32'd2);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_pre_en", 32'(bus.cpu_en), 32'd1);
      tick();
      bus.pc = bus.pc + 32'd4;
    end
    #1;
    check("bp_en_off", 32'(bus.cpu_en), 32'd0);
    tick();
    check("bp_state", 32'(bus.state), 32'd1);
    check("bp_hit", 32'(bus.bp_hit), 32'd1);
    check("bp_ins", 32'(bus.instr_cnt), 32'd7);
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    check("res_hitclr", 32'(bus.bp_hit), 32'd0);
    #1;
    check("res_en", 32'(bus.cpu_en), 32'd1);
    tick();
    bus.pc = 32'h14;
    check("res_ins", 32'(bus.instr_cnt), 32'd8);
    check("res_state", 32'(bus.state), 32'd2);

    // 4: request priority
    bus.halt_req = 1'b1;
    bus.step_req = 1'b1;
    #1;
    check("hs_en", 32'(bus.cpu_en), 32'd1);
    tick();
    bus.step_req = 1'b0;
    check("hs_state", 32'(bus.state), 32'd1);
    check("hs_ins", 32'(bus.instr_cnt), 32'd9);
    bus.run_req = 1'b1;
    tick();
    bus.run_req  = 1'b0;
    bus.halt_req = 1'b0;
    check("hr_state", 32'(bus.state), 32'd1);
    bus.pc      = 32'h0C;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    tick();
    check("hm_ins0", 32'(bus.instr_cnt), 32'd10);
    bus.pc       = 32'h10;
    bus.halt_req = 1'b1;
    #1;
    check("hm_en", 32'(bus.cpu_en), 32'd0);
    tick();
    bus.halt_req = 1'b0;
    check("hm_state", 32'(bus.state), 32'd1);
    check("hm_hit", 32'(bus.bp_hit), 32'd1);
    check("hm_ins", 32'(bus.instr_cnt), 32'd10);

    // 5: async reset while running
    bus.bp_en   = 1'b0;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    check("ar_en_pre", 32'(bus.cpu_en), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check("ar_en", 32'(bus.cpu_en), 32'd0);
    check("ar_cpurst", 32'(bus.cpu_rst), 32'd1);
    check("ar_state", 32'(bus.state), 32'd0);
    check("ar_cyc", 32'(bus.cycle_cnt), 32'd0);
    check("ar_ins", 32'(bus.instr_cnt), 32'd0);
    check("ar_hit", 32'(bus.bp_hit), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    check("ar_hold3", 32'(bus.cpu_rst), 32'd1);
    tick();
    check("ar_hold4", 32'(bus.state), 32'd1);

    // 6: a0 snapshot and 4-bit counter wrap
    bus.a0 = 32'h2A;
    tick();
    check("snap", bus.a0_snap, 32'h2A);
    check("wr_cyc1", 32'(bus.cycle_cnt), 32'd1);
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    bus.a0      = 32'h55;
    check("wr_run", 32'(bus.state), 32'd2);
    repeat (13) tick();
    check("wr_cyc15", 32'(bus.cycle_cnt), 32'd15);
    check("snap_hold", bus.a0_snap, 32'h2A);
    tick();
    check("wr_cyc0", 32'(bus.cycle_cnt), 32'd0);
    tick();
    check("wr_cyc1b", 32'(bus.cycle_cnt), 32'd1);
    check("wr_ins", 32'(bus.instr_cnt), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
